// File: rtl/demux_latched_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 31-channel demux and its companion 31-input mux.
// Both sides use this package so that their select-code maps stay identical.
//   N_CH         : number of channels (31)
//   SEL_W        : select code width (5)
//   SEL_RESERVED : code that addresses no channel
//   SEL_CH30     : code that addresses channel 30
//   sel_to_ch()  : decodes a select code into {valid, channel index}
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int N_CH  = 31;
  localparam int SEL_W = 5;

  localparam logic [SEL_W-1:0] SEL_RESERVED = 5'b11110;
  localparam logic [SEL_W-1:0] SEL_CH30     = 5'b11111;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] ch;
  } ch_dec_t;

  // Codes 0..29 map straight through, 31 maps to channel 30.
  // Code 30 is reserved and reported as invalid.
  function automatic ch_dec_t sel_to_ch(input logic [SEL_W-1:0] sel);
    ch_dec_t r;
    case (sel)
      SEL_RESERVED: begin
        r.valid = 1'b0;
        r.ch    = 5'd0;
      end
      SEL_CH30: begin
        r.valid = 1'b1;
        r.ch    = 5'd30;
      end
      default: begin
        r.valid = 1'b1;
        r.ch    = sel;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/demux_latched_if.sv
// -----------------------------------------------------------------------------
// demux_latched_if
// Write-side bus of the latched demux.
//   sel      : channel select code
//   inp      : write data (DW bits)
//   in_valid : write strobe, sel/inp sampled when high
//   commit   : shadow-to-output transfer strobe
// master drives the bus, slave (the demux) receives it.
// -----------------------------------------------------------------------------
interface demux_latched_if #(
  parameter int DW = 2
);
  import demux_pkg::*;

  logic [SEL_W-1:0] sel;
  logic [DW-1:0]    inp;
  logic             in_valid;
  logic             commit;

  modport master (
    output sel,
    output inp,
    output in_valid,
    output commit
  );

  modport slave (
    input sel,
    input inp,
    input in_valid,
    input commit
  );

endinterface

// File: rtl/demux_latched_chan_reg.sv
// -----------------------------------------------------------------------------
// demux_chan_reg
// One demux channel: shadow register, committed output register, dirty bit.
//   clk, rst : clock, synchronous active-high reset
//   we       : write this channel's shadow with wdata
//   wdata    : write data
//   commit   : copy shadow into the output register, clear dirty
//   qout     : committed value (registered)
//   dirty    : channel written since last commit (registered)
// -----------------------------------------------------------------------------
module demux_chan_reg #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic          commit,
  output logic [DW-1:0] qout,
  output logic          dirty
);

  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] out_q,    out_d;
  logic          dirty_q,  dirty_d;

  // Next-state: a write in the commit cycle reaches the output through shadow_d.
  always_comb begin
    shadow_d = shadow_q;
    out_d    = out_q;
    dirty_d  = dirty_q;

    if (we) begin
      shadow_d = wdata;
    end else begin
      shadow_d = shadow_q;
    end

    if (commit) begin
      out_d   = shadow_d;
      dirty_d = 1'b0;
    end else if (we) begin
      out_d   = out_q;
      dirty_d = 1'b1;
    end else begin
      out_d   = out_q;
      dirty_d = dirty_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= {DW{1'b0}};
      out_q    <= {DW{1'b0}};
      dirty_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      out_q    <= out_d;
      dirty_q  <= dirty_d;
    end
  end

  assign qout  = out_q;
  assign dirty = dirty_q;

endmodule

// File: rtl/demux_latched.sv
// -----------------------------------------------------------------------------
// demux_latched
// Addressed 1-to-31 demultiplexer with double-buffered outputs. Writes land in
// per-channel shadow registers; a commit moves all shadows to the outputs on
// one edge. Uses the same select-code map as the 31-input mux.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : write bus (sel, inp, in_valid, commit), slave side
//   out0..out30  : committed channel values
//   dirty        : per-channel "written since last commit"
//   committed    : one-cycle pulse the cycle after a commit
//   err          : sticky, set by a write to the reserved code
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module demux_latched
  import demux_pkg::*;
#(
  parameter int DW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_latched_if.slave       bus,
  output logic [DW-1:0]        out0,
  output logic [DW-1:0]        out1,
  output logic [DW-1:0]        out2,
  output logic [DW-1:0]        out3,
  output logic [DW-1:0]        out4,
  output logic [DW-1:0]        out5,
  output logic [DW-1:0]        out6,
  output logic [DW-1:0]        out7,
  output logic [DW-1:0]        out8,
  output logic [DW-1:0]        out9,
  output logic [DW-1:0]        out10,
  output logic [DW-1:0]        out11,
  output logic [DW-1:0]        out12,
  output logic [DW-1:0]        out13,
  output logic [DW-1:0]        out14,
  output logic [DW-1:0]        out15,
  output logic [DW-1:0]        out16,
  output logic [DW-1:0]        out17,
  output logic [DW-1:0]        out18,
  output logic [DW-1:0]        out19,
  output logic [DW-1:0]        out20,
  output logic [DW-1:0]        out21,
  output logic [DW-1:0]        out22,
  output logic [DW-1:0]        out23,
  output logic [DW-1:0]        out24,
  output logic [DW-1:0]        out25,
  output logic [DW-1:0]        out26,
  output logic [DW-1:0]        out27,
  output logic [DW-1:0]        out28,
  output logic [DW-1:0]        out29,
  output logic [DW-1:0]        out30,
  output logic [N_CH-1:0]      dirty,
  output logic                 committed,
  output logic                 err
);

  ch_dec_t          dec_s;
  logic [N_CH-1:0]  we_s;
  logic [N_CH-1:0]  dirty_s;
  logic [DW-1:0]    chan_out_s [N_CH];
  logic             err_q, err_d;
  logic             committed_q;

  // Decode the select code once for all channels.
  always_comb begin
    dec_s = sel_to_ch(bus.sel);
  end

  // One-hot write enable; the reserved code enables no channel.
  always_comb begin
    we_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (bus.in_valid && dec_s.valid && (dec_s.ch == 5'(i))) begin
        we_s[i] = 1'b1;
      end else begin
        we_s[i] = 1'b0;
      end
    end
  end

  // Error flag next-state: only reset clears it.
  always_comb begin
    if (bus.in_valid && !dec_s.valid) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Sticky error flag and the commit acknowledge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      committed_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      committed_q <= bus.commit;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    demux_chan_reg #(.DW(DW)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .we     (we_s[i]),
      .wdata  (bus.inp),
      .commit (bus.commit),
      .qout   (chan_out_s[i]),
      .dirty  (dirty_s[i])
    );
  end

  assign dirty     = dirty_s;
  assign committed = committed_q;
  assign err       = err_q;

  assign out0  = chan_out_s[0];
  assign out1  = chan_out_s[1];
  assign out2  = chan_out_s[2];
  assign out3  = chan_out_s[3];
  assign out4  = chan_out_s[4];
  assign out5  = chan_out_s[5];
  assign out6  = chan_out_s[6];
  assign out7  = chan_out_s[7];
  assign out8  = chan_out_s[8];
  assign out9  = chan_out_s[9];
  assign out10 = chan_out_s[10];
  assign out11 = chan_out_s[11];
  assign out12 = chan_out_s[12];
  assign out13 = chan_out_s[13];
  assign out14 = chan_out_s[14];
  assign out15 = chan_out_s[15];
  assign out16 = chan_out_s[16];
  assign out17 = chan_out_s[17];
  assign out18 = chan_out_s[18];
  assign out19 = chan_out_s[19];
  assign out20 = chan_out_s[20];
  assign out21 = chan_out_s[21];
  assign out22 = chan_out_s[22];
  assign out23 = chan_out_s[23];
  assign out24 = chan_out_s[24];
  assign out25 = chan_out_s[25];
  assign out26 = chan_out_s[26];
  assign out27 = chan_out_s[27];
  assign out28 = chan_out_s[28];
  assign out29 = chan_out_s[29];
  assign out30 = chan_out_s[30];

endmodule

// File: tb/tb_demux_latched.sv
// -----------------------------------------------------------------------------
// tb_demux_latched
// Directed vector table for the latched demux plus hand-written sequences for
// the all-channel commit, mux round-trip and reset-over-commit cases.
// -----------------------------------------------------------------------------
module tb_demux_latched;

  logic        clk;
  logic        rst;
  logic [1:0]  out_arr [31];
  logic [30:0] dirty;
  logic        committed;
  logic        err;

  int checks = 0;
  int errors = 0;

  demux_latched_if #(.DW(2)) bus ();

  demux_latched #(.DW(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .out0(out_arr[0]),   .out1(out_arr[1]),   .out2(out_arr[2]),   .out3(out_arr[3]),
    .out4(out_arr[4]),   .out5(out_arr[5]),   .out6(out_arr[6]),   .out7(out_arr[7]),
    .out8(out_arr[8]),   .out9(out_arr[9]),   .out10(out_arr[10]), .out11(out_arr[11]),
    .out12(out_arr[12]), .out13(out_arr[13]), .out14(out_arr[14]), .out15(out_arr[15]),
    .out16(out_arr[16]), .out17(out_arr[17]), .out18(out_arr[18]), .out19(out_arr[19]),
    .out20(out_arr[20]), .out21(out_arr[21]), .out22(out_arr[22]), .out23(out_arr[23]),
    .out24(out_arr[24]), .out25(out_arr[25]), .out26(out_arr[26]), .out27(out_arr[27]),
    .out28(out_arr[28]), .out29(out_arr[29]), .out30(out_arr[30]),
    .dirty(dirty), .committed(committed), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  sel;
    logic [1:0]  inp;
    logic        cm;
    int          ch;      // channel whose output is checked
    logic [1:0]  e_out;
    logic [30:0] e_dirty;
    logic        e_cm;
    logic        e_err;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic iv, input logic [4:0] s,
                      input logic [1:0] d, input logic c);
    rst          = r;
    bus.in_valid = iv;
    bus.sel      = s;
    bus.inp      = d;
    bus.commit   = c;
    @(posedge clk);
    #1;
  endtask

  // Bench-side mux: code 31 selects channel 30, code 30 reads as 0.
  function automatic logic [1:0] mux_read(input logic [4:0] code);
    if (code == 5'd31) return out_arr[30];
    if (code == 5'd30) return 2'b00;
    return out_arr[code];
  endfunction

  initial begin
    logic [1:0] v2;
    rst = 1'b1; bus.in_valid = 1'b0; bus.sel = 5'd0; bus.inp = 2'd0; bus.commit = 1'b0;

    //            rst   iv    sel      inp    cm    ch  out    dirty          cm    err
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  2'd0, 1'b0,  3, 2'd0, 31'h0,         1'b0, 1'b0}; // reset
    vecs[1]  = '{1'b0, 1'b1, 5'd3,  2'd2, 1'b0,  3, 2'd0, 31'h8,         1'b0, 1'b0}; // write ch3
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  2'd0, 1'b1,  3, 2'd2, 31'h0,         1'b1, 1'b0}; // commit
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  2'd0, 1'b0,  3, 2'd2, 31'h0,         1'b0, 1'b0}; // pulse ends
    vecs[4]  = '{1'b0, 1'b1, 5'd31, 2'd3, 1'b0, 30, 2'd0, 31'h4000_0000, 1'b0, 1'b0}; // write ch30
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  2'd0, 1'b1, 30, 2'd3, 31'h0,         1'b1, 1'b0}; // commit
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 29, 2'd0, 31'h0,         1'b0, 1'b0}; // ch29 untouched
    vecs[7]  = '{1'b0, 1'b1, 5'd30, 2'd1, 1'b0, 30, 2'd3, 31'h0,         1'b0, 1'b1}; // reserved
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  2'd0, 1'b1, 30, 2'd3, 31'h0,         1'b1, 1'b1}; // err sticky
    vecs[9]  = '{1'b0, 1'b1, 5'd5,  2'd1, 1'b0,  5, 2'd0, 31'h20,        1'b0, 1'b1}; // ch5=1
    vecs[10] = '{1'b0, 1'b1, 5'd5,  2'd3, 1'b0,  5, 2'd0, 31'h20,        1'b0, 1'b1}; // ch5=3
    vecs[11] = '{1'b0, 1'b0, 5'd0,  2'd0, 1'b1,  5, 2'd3, 31'h0,         1'b1, 1'b1}; // last wins
    vecs[12] = '{1'b0, 1'b1, 5'd7,  2'd2, 1'b1,  7, 2'd2, 31'h0,         1'b1, 1'b1}; // bypass
    vecs[13] = '{1'b0, 1'b0, 5'd7,  2'd1, 1'b1,  7, 2'd2, 31'h0,         1'b1, 1'b1}; // b2b commit
    vecs[14] = '{1'b0, 1'b0, 5'd3,  2'd0, 1'b0,  3, 2'd2, 31'h0,         1'b0, 1'b1}; // iv=0 ignored
    vecs[15] = '{1'b1, 1'b0, 5'd0,  2'd0, 1'b0,  7, 2'd0, 31'h0,         1'b0, 1'b0}; // reset clears

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].inp, vecs[i].cm);
      chk($sformatf("v%0d out%0d", i, vecs[i].ch), {30'd0, out_arr[vecs[i].ch]}, {30'd0, vecs[i].e_out});
      chk($sformatf("v%0d dirty", i), {1'b0, dirty}, {1'b0, vecs[i].e_dirty});
      chk($sformatf("v%0d committed", i), {31'd0, committed}, {31'd0, vecs[i].e_cm});
      chk($sformatf("v%0d err", i), {31'd0, err}, {31'd0, vecs[i].e_err});
    end

    // All 31 channels written with their index bits, one commit.
    for (int c = 0; c < 31; c++) begin
      v2 = 2'(c);
      step(1'b0, 1'b1, (c == 30) ? 5'd31 : 5'(c), v2, 1'b0);
    end
    chk("all dirty", {1'b0, dirty}, 32'h7FFF_FFFF);
    for (int c = 0; c < 31; c++) chk($sformatf("pre out%0d", c), {30'd0, out_arr[c]}, 32'd0);
    step(1'b0, 1'b0, 5'd0, 2'd0, 1'b1);
    chk("all commit dirty", {1'b0, dirty}, 32'd0);
    chk("all commit pulse", {31'd0, committed}, 32'd1);
    for (int c = 0; c < 31; c++) begin
      v2 = 2'(c);
      chk($sformatf("all out%0d", c), {30'd0, out_arr[c]}, {30'd0, v2});
    end
    // Mux round-trip: code c returns the value written with code c.
    for (int c = 0; c < 32; c++) begin
      if (c != 30) begin
        v2 = (c == 31) ? 2'(30) : 2'(c);
        chk($sformatf("mux code%0d", c), {30'd0, mux_read(5'(c))}, {30'd0, v2});
      end
    end

    // Reset over a simultaneous write+commit.
    step(1'b0, 1'b1, 5'd0, 2'd3, 1'b0);
    step(1'b0, 1'b0, 5'd0, 2'd0, 1'b1);
    chk("rst pre out0", {30'd0, out_arr[0]}, 32'd3);
    step(1'b0, 1'b1, 5'd30, 2'd1, 1'b0);
    chk("rst pre err", {31'd0, err}, 32'd1);
    step(1'b1, 1'b1, 5'd0, 2'd1, 1'b1);
    for (int c = 0; c < 31; c++) chk($sformatf("rst out%0d", c), {30'd0, out_arr[c]}, 32'd0);
    chk("rst dirty", {1'b0, dirty}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst committed", {31'd0, committed}, 32'd0);
    // Discarded write must not reappear on a later commit.
    step(1'b0, 1'b0, 5'd0, 2'd0, 1'b1);
    chk("post rst out0", {30'd0, out_arr[0]}, 32'd0);
    chk("post rst pulse", {31'd0, committed}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
